// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory responder: FSM encoding,
// default base address and the delay LFSR seed.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } imem_state_e;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;
    localparam logic [7:0]  LFSR_SEED         = 8'hA5;

endpackage

// File: rtl/imem_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) free-running every cycle; the low three
// bits supply a pseudo-random fetch delay.
module imem_lfsr
    import imem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [2:0] delay_o
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign delay_o = lfsr_q[2:0];

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: one fetch at a time with a fixed (or, with
// IMEM_RAND_DELAY_EN defined, LFSR-driven) delay and a preload write port.
//
// state | meaning
// IDLE  | ready for a fetch request
// WAIT  | counting down the access delay
// RESP  | response presented until the requester takes it
module imem_responder
    import imem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [31:0]              req_addr,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [31:0]              resp_data,
    output logic                     resp_err,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_idx,
    input  logic [31:0]              ld_data
);

    localparam int          IW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(DEPTH * 4);

    imem_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;
    logic [31:0] mem_q [DEPTH];

    logic [31:0]   cap_addr;
    logic [31:0]   cap_off;
    logic [IW-1:0] cap_idx;
    logic          cap_err;
    logic [3:0]    load_cnt;

`ifdef IMEM_RAND_DELAY_EN
    logic [2:0] rand_delay;

    imem_lfsr u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .delay_o (rand_delay)
    );

    assign load_cnt = {1'b0, rand_delay};
`else
    assign load_cnt = 4'(LATENCY);
`endif

    // With a zero delay the word is captured straight from the request bus.
    assign cap_addr = (state_q == IDLE) ? req_addr : addr_q;
    assign cap_off  = cap_addr - BASE_ADDR;
    assign cap_idx  = cap_off[IW+1:2];
    assign cap_err  = (cap_addr[1:0] != 2'b00) || (cap_off >= SPAN);

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_data  = data_q;
    assign resp_err   = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d = req_addr;
                    cnt_d  = load_cnt;
                    if (load_cnt == 4'd0) begin
                        state_d = RESP;
                        data_d  = cap_err ? 32'd0 : mem_q[cap_idx];
                        err_d   = cap_err;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = RESP;
                    data_d  = cap_err ? 32'd0 : mem_q[cap_idx];
                    err_d   = cap_err;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            data_q  <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // Read of the captured word above sees the pre-write value on a same-edge preload.
    always_ff @(posedge clk) begin
        if (ld_en && !rst) begin
            mem_q[ld_idx] <= ld_data;
        end
    end

endmodule
